// File: rtl/reg_writeback_queue_if.sv
// Bundles the result-side handshake, register-file write port, occupancy and
// forwarding lookup signals of reg_writeback_queue.
interface reg_writeback_queue_if #(
   parameter int DEPTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [4:0]               in_rd;
   logic [63:0]              in_data;
   logic                     wb_hold;
   logic                     reg_write;
   logic [4:0]               write_register;
   logic [63:0]              write_data;
   logic [$clog2(DEPTH):0]   count;
   logic [4:0]               fwd_reg_1;
   logic [4:0]               fwd_reg_2;
   logic                     fwd_hit_1;
   logic                     fwd_hit_2;
   logic [63:0]              fwd_data_1;
   logic [63:0]              fwd_data_2;

   modport master (
      output in_valid, in_rd, in_data, wb_hold, fwd_reg_1, fwd_reg_2,
      input  in_ready, reg_write, write_register, write_data, count,
      input  fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2
   );

   modport slave (
      input  in_valid, in_rd, in_data, wb_hold, fwd_reg_1, fwd_reg_2,
      output in_ready, reg_write, write_register, write_data, count,
      output fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2
   );
endinterface

// File: rtl/reg_writeback_queue.sv
// Writeback FIFO feeding the register file write port, one entry per cycle.
// Define WBQ_FORWARD_EN to add forwarding lookup of still-pending writes.
module reg_writeback_queue #(
   parameter int DEPTH     = 4,
   parameter bit ZERO_DROP = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   reg_writeback_queue_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [4:0]    r_rd   [DEPTH];
   logic [63:0]   r_data [DEPTH];
   logic [AW-1:0] r_rdPtr;
   logic [AW-1:0] r_wrPtr;
   logic [CW-1:0] r_count;
   logic          r_regWrite;
   logic [4:0]    r_writeRegister;
   logic [63:0]   r_writeData;

   logic w_inReady;
   logic w_accept;
   logic w_drop;
   logic w_push;
   logic w_pop;

   // Full is judged from the count alone, so a pop in the same cycle never frees a slot early.
   assign w_inReady = rst_n && (r_count < CW'(DEPTH));
   assign w_accept  = bus.in_valid && w_inReady;
   assign w_drop    = ZERO_DROP && (bus.in_rd == 5'd0);
   assign w_push    = w_accept && !w_drop;
   assign w_pop     = (r_count != '0) && !bus.wb_hold;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_rd[r_wrPtr]   <= bus.in_rd;
         r_data[r_wrPtr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdPtr         <= '0;
         r_wrPtr         <= '0;
         r_count         <= '0;
         r_regWrite      <= 1'b0;
         r_writeRegister <= '0;
         r_writeData     <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_regWrite <= w_pop;
         if (w_pop) begin
            r_writeRegister <= r_rd[r_rdPtr];
            r_writeData     <= r_data[r_rdPtr];
         end
      end
   end

   assign bus.in_ready       = w_inReady;
   assign bus.count          = r_count;
   assign bus.reg_write      = r_regWrite;
   assign bus.write_register = r_writeRegister;
   assign bus.write_data     = r_writeData;

`ifdef WBQ_FORWARD_EN
   logic          w_hit1;
   logic          w_hit2;
   logic [63:0]   w_fwdData1;
   logic [63:0]   w_fwdData2;
   logic [AW-1:0] w_idx;

   // Scan oldest to youngest (output stage first, then queue from head) so later matches win.
   always_comb begin
      w_hit1     = 1'b0;
      w_hit2     = 1'b0;
      w_fwdData1 = '0;
      w_fwdData2 = '0;
      w_idx      = '0;
      if (r_regWrite && (r_writeRegister == bus.fwd_reg_1)) begin
         w_hit1     = 1'b1;
         w_fwdData1 = r_writeData;
      end
      if (r_regWrite && (r_writeRegister == bus.fwd_reg_2)) begin
         w_hit2     = 1'b1;
         w_fwdData2 = r_writeData;
      end
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_rdPtr + AW'(k);
         if ((CW'(k) < r_count) && (r_rd[w_idx] == bus.fwd_reg_1)) begin
            w_hit1     = 1'b1;
            w_fwdData1 = r_data[w_idx];
         end
         if ((CW'(k) < r_count) && (r_rd[w_idx] == bus.fwd_reg_2)) begin
            w_hit2     = 1'b1;
            w_fwdData2 = r_data[w_idx];
         end
      end
      if (ZERO_DROP && (bus.fwd_reg_1 == 5'd0)) begin
         w_hit1     = 1'b0;
         w_fwdData1 = '0;
      end
      if (ZERO_DROP && (bus.fwd_reg_2 == 5'd0)) begin
         w_hit2     = 1'b0;
         w_fwdData2 = '0;
      end
   end

   assign bus.fwd_hit_1  = w_hit1;
   assign bus.fwd_hit_2  = w_hit2;
   assign bus.fwd_data_1 = w_fwdData1;
   assign bus.fwd_data_2 = w_fwdData2;
`else
   logic w_unusedFwd;

   assign w_unusedFwd    = ^{bus.fwd_reg_1, bus.fwd_reg_2};
   assign bus.fwd_hit_1  = 1'b0;
   assign bus.fwd_hit_2  = 1'b0;
   assign bus.fwd_data_1 = '0;
   assign bus.fwd_data_2 = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed-vector bench for reg_writeback_queue with hand-computed expectations.
module tb_reg_writeback_queue;
`ifdef WBQ_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   reg_writeback_queue_if #(.DEPTH(4)) bus ();

   reg_writeback_queue #(.DEPTH(4), .ZERO_DROP(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic valid, input logic [4:0] rd,
                                input logic [63:0] data, input logic hold);
      bus.in_valid = valid;
      bus.in_rd    = rd;
      bus.in_data  = data;
      bus.wb_hold  = hold;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
      bus.fwd_reg_1 = 5'd0;
      bus.fwd_reg_2 = 5'd0;

      // Reset state
      @(negedge clk);
      checkOutput("rst_reg_write", bus.reg_write, 0);
      checkOutput("rst_count", bus.count, 0);
      checkOutput("rst_in_ready", bus.in_ready, 0);
      checkOutput("rst_write_register", bus.write_register, 0);
      checkOutput("rst_write_data", bus.write_data, 0);
      rst_n = 1'b1;
      #1;
      checkOutput("post_rst_in_ready", bus.in_ready, 1);

      // Single entry latency
      applyStimulus(1'b1, 5'd5, 64'h0000_0000_DEAD_BEEF, 1'b0);
      step();
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
      checkOutput("single_count_after_push", bus.count, 1);
      checkOutput("single_no_write_yet", bus.reg_write, 0);
      step();
      checkOutput("single_reg_write", bus.reg_write, 1);
      checkOutput("single_write_register", bus.write_register, 5);
      checkOutput("single_write_data", bus.write_data, 64'hDEAD_BEEF);
      checkOutput("single_count_drained", bus.count, 0);
      step();
      checkOutput("single_reg_write_off", bus.reg_write, 0);
      checkOutput("single_count_final", bus.count, 0);

      // Fill under hold, stall the fifth offer, then drain in order
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 5'(i), 64'(i * 8'h11), 1'b1);
         step();
      end
      checkOutput("fill_count", bus.count, 4);
      checkOutput("fill_in_ready", bus.in_ready, 0);
      checkOutput("fill_no_write", bus.reg_write, 0);
      applyStimulus(1'b1, 5'd9, 64'h55, 1'b1);
      step();
      checkOutput("stall_count", bus.count, 4);
      checkOutput("stall_in_ready", bus.in_ready, 0);
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         step();
         checkOutput($sformatf("drain%0d_reg_write", i), bus.reg_write, 1);
         checkOutput($sformatf("drain%0d_rd", i), bus.write_register, 64'(i));
         checkOutput($sformatf("drain%0d_data", i), bus.write_data, 64'(i * 8'h11));
         checkOutput($sformatf("drain%0d_in_ready", i), bus.in_ready, 1);
      end
      step();
      checkOutput("drain_done_reg_write", bus.reg_write, 0);
      checkOutput("drain_done_count", bus.count, 0);

      // Streaming push and pop, wrapping the pointers
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 5'(10 + k), 64'h100 + 64'(k), 1'b0);
         step();
         checkOutput($sformatf("stream%0d_count", k), bus.count, 1);
         if (k == 0) begin
            checkOutput("stream0_reg_write", bus.reg_write, 0);
         end else begin
            checkOutput($sformatf("stream%0d_reg_write", k), bus.reg_write, 1);
            checkOutput($sformatf("stream%0d_rd", k), bus.write_register, 64'(9 + k));
            checkOutput($sformatf("stream%0d_data", k), bus.write_data, 64'h100 + 64'(k - 1));
         end
      end
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
      step();
      checkOutput("stream_last_rd", bus.write_register, 19);
      checkOutput("stream_last_data", bus.write_data, 64'h109);
      checkOutput("stream_last_count", bus.count, 0);
      step();
      checkOutput("stream_idle", bus.reg_write, 0);

      // Index 0 results are accepted but discarded
      applyStimulus(1'b1, 5'd0, 64'h99, 1'b0);
      #1;
      checkOutput("zero_in_ready", bus.in_ready, 1);
      step();
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
      checkOutput("zero_count", bus.count, 0);
      checkOutput("zero_no_write_1", bus.reg_write, 0);
      step();
      checkOutput("zero_no_write_2", bus.reg_write, 0);

      // Forwarding: youngest queued match, then output stage match
      applyStimulus(1'b1, 5'd7, 64'hA, 1'b1);
      step();
      applyStimulus(1'b1, 5'd7, 64'hB, 1'b1);
      step();
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b1);
      bus.fwd_reg_1 = 5'd7;
      bus.fwd_reg_2 = 5'd8;
      #1;
      checkOutput("fwd_hit_1", bus.fwd_hit_1, FWD ? 64'd1 : 64'd0);
      checkOutput("fwd_data_1", bus.fwd_data_1, FWD ? 64'hB : 64'd0);
      checkOutput("fwd_hit_2", bus.fwd_hit_2, 0);
      checkOutput("fwd_data_2", bus.fwd_data_2, 0);
      bus.fwd_reg_2 = 5'd0;
      #1;
      checkOutput("fwd_zero_no_hit", bus.fwd_hit_2, 0);
      bus.wb_hold = 1'b0;
      step();
      checkOutput("fwd_pop1_hit", bus.fwd_hit_1, FWD ? 64'd1 : 64'd0);
      checkOutput("fwd_pop1_data", bus.fwd_data_1, FWD ? 64'hB : 64'd0);
      step();
      checkOutput("fwd_stage_rd", bus.write_register, 7);
      checkOutput("fwd_stage_hit", bus.fwd_hit_1, FWD ? 64'd1 : 64'd0);
      checkOutput("fwd_stage_data", bus.fwd_data_1, FWD ? 64'hB : 64'd0);
      step();
      checkOutput("fwd_clear_hit", bus.fwd_hit_1, 0);
      checkOutput("fwd_clear_count", bus.count, 0);

      // Asynchronous reset with entries queued and a write in flight
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'(20 + i), 64'h200 + 64'(i), 1'b1);
         step();
      end
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
      step();
      checkOutput("pre_rst_count", bus.count, 3);
      checkOutput("pre_rst_reg_write", bus.reg_write, 1);
      checkOutput("pre_rst_rd", bus.write_register, 20);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_reg_write", bus.reg_write, 0);
      checkOutput("async_rst_count", bus.count, 0);
      checkOutput("async_rst_in_ready", bus.in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput($sformatf("post_rst%0d_no_write", i), bus.reg_write, 0);
         checkOutput($sformatf("post_rst%0d_count", i), bus.count, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
Producer side of the register file write port. Buffers completed results (destination index plus 64-bit data) from execute and load units in a small FIFO. Drains at most one entry per cycle onto the register file's reg_write / write_register / write_data inputs. Optionally supplies forwarding data for register indexes that are still pending, so the decode read side sees values not yet committed.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
ZERO_DROP, 1, 1 = results targeting index 0 complete the handshake but are discarded, never enqueued

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  result offered
in_ready  output  1  queue can accept
in_rd  input  5  destination register index
in_data  input  64  result data
wb_hold  input  1  suppress draining this cycle
reg_write  output  1  registered write strobe to register file
write_register  output  5  registered write index
write_data  output  64  registered write data
count  output  clog2(DEPTH)+1  entries currently queued (excludes output stage)
fwd_reg_1  input  5  forwarding lookup index, port 1
fwd_reg_2  input  5  forwarding lookup index, port 2
fwd_hit_1  output  1  pending write to fwd_reg_1 exists
fwd_hit_2  output  1  pending write to fwd_reg_2 exists
fwd_data_1  output  64  youngest pending data for fwd_reg_1
fwd_data_2  output  64  youngest pending data for fwd_reg_2

Behaviour:
- Reset (rst_n low, asynchronous): queue emptied, count=0, reg_write=0, write_register=0, write_data=0; in_ready=0 while rst_n low.
- Accept: transfer occurs on a rising edge with in_valid && in_ready.
- in_ready = rst_n && (count < DEPTH). There is no same-cycle pass-through when full, even if a pop happens in the same cycle.
- in_valid may be held across cycles. in_rd and in_data must stay stable while in_valid && !in_ready.
- ZERO_DROP=1 and in_rd==0: the handshake completes, but nothing is enqueued and count is unchanged.
- Pop: on each edge where count>0 && !wb_hold:
  - the head entry moves into the output stage;
  - reg_write=1, write_register=head.rd, write_data=head.data for the following cycle.
- Otherwise reg_write=0 for the following cycle. write_register and write_data hold their last values.
- Latency: an entry accepted at edge N into an empty queue (wb_hold low) drives reg_write during cycle N+1. The register file commits it at edge N+2. Throughput is one entry per cycle.
- Simultaneous push and pop: count is unchanged, and order is preserved (strict FIFO).
- wb_hold asserted mid-stream: the output stage deasserts reg_write the next cycle, and entries remain queued. The queue fills to DEPTH, then in_ready drops.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Full and empty are distinguished by count, not by pointer equality.
- Reset mid-operation: all queued entries are lost, and no write strobe is emitted after rst_n rises until a new entry is accepted.
- write_data is passed through unmodified at 64 bits. Truncation to register width is the register file's responsibility.

Optional Feature:
Macro WBQ_FORWARD_EN.
- Defined:
  - fwd_hit_x=1 if any valid queue entry or an asserted output stage (reg_write=1) has rd==fwd_reg_x.
  - fwd_data_x is taken from the youngest match. Queue entries rank youngest by write order, and all queue entries are younger than the output stage.
  - The lookup is combinational within the cycle and ignores the same-cycle incoming in_* values.
  - fwd_reg_x==0 with ZERO_DROP=1 never hits.
- Undefined: fwd_hit_1, fwd_hit_2, fwd_data_1 and fwd_data_2 are tied to 0, and the lookup logic is absent.

Test Plan:
- Reset, then push rd=5 data=0x0000_0000_DEAD_BEEF with wb_hold=0 -> cycle N+1: reg_write=1, write_register=5, write_data=0xDEADBEEF; cycle N+2: reg_write=0, count=0.
- wb_hold=1, push 4 entries (rd=1..4, data=0x11..0x44) -> count=4, in_ready=0, a 5th in_valid stalls. Release hold -> four consecutive reg_write cycles with rd 1,2,3,4 in order, then in_ready=1.
- Continuous push and pop for 10 cycles with an incrementing rd -> count stays at 1, outputs appear in order with no gaps, and pointers wrap without loss.
- ZERO_DROP=1, push rd=0 data=0x99 -> handshake completes, count stays 0, and reg_write is never asserted.
- WBQ_FORWARD_EN, wb_hold=1, push rd=7 data=0xA then rd=7 data=0xB, fwd_reg_1=7 -> fwd_hit_1=1, fwd_data_1=0xB; fwd_reg_2=8 -> fwd_hit_2=0.
- Assert rst_n=0 asynchronously with 3 entries queued and reg_write=1 -> reg_write drops immediately and count=0. After release, no writes occur.
